// File: rtl/data_sram_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_if / mem_port_if
//  Description : Signal bundles for data_sram_bridge.
//                data_sram_if : core-side single-cycle data_sram port plus the
//                               stall request back to the pipeline.
//                  master = CPU pipeline (EX drives request, MEM reads rdata)
//                  slave  = bridge
//                mem_port_if  : variable-latency req/ack memory port.
//                  master = bridge
//                  slave  = memory
//  Ports       : none (bundles only); clk/resetn stay plain module ports.
//  Revision    : 1.0 - initial release
// ============================================================================

interface data_sram_if;
  logic        data_sram_en;     // access request from EX
  logic [3:0]  data_sram_wen;    // byte write enables, 0 = read
  logic [31:0] data_sram_addr;   // byte address
  logic [31:0] data_sram_wdata;  // lane-positioned store data
  logic [31:0] data_sram_rdata;  // load data consumed by MEM
  logic        stallreq;         // stall request to the stall controller

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq
  );
endinterface : data_sram_if

interface mem_port_if;
  logic        mem_req;    // request, held until ack or timeout
  logic        mem_wr;     // 1 = write, 0 = read
  logic [3:0]  mem_wstrb;  // byte strobes
  logic [31:0] mem_addr;   // word-aligned address
  logic [31:0] mem_wdata;  // store data
  logic        mem_ack;    // completion, valid only while mem_req = 1
  logic [31:0] mem_rdata;  // read data, valid with mem_ack on reads
  logic        mem_err;    // sticky timeout flag

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_err,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_err,
    output mem_ack, mem_rdata
  );
endinterface : mem_port_if

`default_nettype wire

// File: rtl/data_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_bridge
//  Description : Responder for the core's data_sram port. Each single-cycle
//                data_sram request is turned into one req/ack transaction on
//                a variable-latency memory port. The pipeline is stalled
//                until the transaction finishes, then released for exactly
//                one cycle. Load data is held in a register so the MEM stage
//                sees a stable value until the next completed read.
//
//                A transaction that sees no ack within MAX_WAIT request
//                cycles is abandoned: mem_err is set (sticky until reset) and
//                a read returns ERR_RDATA.
//
//  Parameters  : MAX_WAIT  - request cycles before timeout, legal 1..255
//                ERR_RDATA - load data returned by a timed-out read
//
//  Ports       : clk    - clock
//                resetn - asynchronous active-low reset
//                sram   - data_sram_if.slave  (en/wen/addr/wdata in,
//                                              rdata/stallreq out)
//                mem    - mem_port_if.master  (req/wr/wstrb/addr/wdata/err
//                                              out, ack/rdata in)
//  Revision    : 1.0 - initial release
// ============================================================================

module data_sram_bridge #(
  parameter int unsigned MAX_WAIT  = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic       clk,
  input  logic       resetn,
  data_sram_if.slave sram,
  mem_port_if.master mem
);

  // Counter value on the last request cycle that may still see an ack.
  localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a CPU access
    ST_REQ  = 2'd1,  // memory request outstanding
    ST_DONE = 2'd2   // one-cycle release of the pipeline
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_accept;    // capture a new access this cycle
  logic        w_ack;       // transaction completes normally this cycle
  logic        w_timeout;   // transaction abandoned this cycle
  logic        w_stall;     // stall request before reset gating

  logic        r_wr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_wait_cnt;
  logic        r_err;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // The pipeline must freeze in the same cycle the access appears.
        w_stall = sram.data_sram_en;
        if (sram.data_sram_en) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        w_stall = 1'b1;
        // Ack is checked first so an ack on the final allowed cycle still
        // completes normally instead of being reported as a timeout.
        if (mem.mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_wait_cnt == c_wait_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        // en still shows the access just finished; it must not be taken
        // again, so nothing is accepted here.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Captured request: held constant for the whole REQ phase
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= 1'b0;
      r_wstrb <= 4'b0000;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_wr    <= (sram.data_sram_wen != 4'b0000);
      r_wstrb <= sram.data_sram_wen;
      // Byte offset is carried by wen (stores) and by MEM-stage extraction
      // (loads), so the memory only ever sees word addresses.
      r_addr  <= sram.data_sram_addr & 32'hFFFF_FFFC;
      r_wdata <= sram.data_sram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Wait counter: counts request cycles that went without an ack
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= 8'd0;
    end else if (w_accept) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == ST_REQ) && !w_ack && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Load data: changes only when a read finishes (normally or by timeout)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0000_0000;
    end else if (w_ack && !r_wr) begin
      r_rdata <= mem.mem_rdata;
    end else if (w_timeout && !r_wr) begin
      r_rdata <= ERR_RDATA;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky timeout flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // mem_req is decoded from the state register so it falls the moment reset
  // is asserted, without waiting for an ack or a clock edge.
  assign mem.mem_req   = (r_state == ST_REQ);
  assign mem.mem_wr    = r_wr;
  assign mem.mem_wstrb = r_wstrb;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_err   = r_err;

  assign sram.data_sram_rdata = r_rdata;
  // In IDLE the stall follows en combinationally; gating with resetn keeps
  // the stall low while reset is held even if the CPU still drives en.
  assign sram.stallreq = resetn & w_stall;

endmodule : data_sram_bridge

`default_nettype wire

// File: tb/tb_data_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_bridge
//  Description : Self-checking bench for data_sram_bridge. Two instances are
//                built: A with the default MAX_WAIT and B with MAX_WAIT = 4
//                for the timeout cases. One set of stimulus variables is
//                steered to the selected instance; the other sees en = 0 and
//                ack = 0 and stays idle.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_data_sram_bridge;

  localparam int unsigned c_max_wait_b = 4;
  localparam int          c_budget     = 300;

  logic        clk;
  logic        resetn;
  logic        r_sel;      // 0 = instance A, 1 = instance B
  logic        r_en;
  logic [3:0]  r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ack;
  logic [31:0] r_mrdata;

  data_sram_if sa ();
  data_sram_if sb ();
  mem_port_if  ma ();
  mem_port_if  mb ();

  assign sa.data_sram_en    = r_en & ~r_sel;
  assign sb.data_sram_en    = r_en & r_sel;
  assign sa.data_sram_wen   = r_wen;
  assign sb.data_sram_wen   = r_wen;
  assign sa.data_sram_addr  = r_addr;
  assign sb.data_sram_addr  = r_addr;
  assign sa.data_sram_wdata = r_wdata;
  assign sb.data_sram_wdata = r_wdata;
  assign ma.mem_ack         = r_ack & ~r_sel;
  assign mb.mem_ack         = r_ack & r_sel;
  assign ma.mem_rdata       = r_mrdata;
  assign mb.mem_rdata       = r_mrdata;

  data_sram_bridge u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .sram   (sa),
    .mem    (ma)
  );

  data_sram_bridge #(
    .MAX_WAIT  (c_max_wait_b),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .sram   (sb),
    .mem    (mb)
  );

  // Observed outputs of the selected instance.
  wire         w_obs_req   = r_sel ? mb.mem_req   : ma.mem_req;
  wire         w_obs_wr    = r_sel ? mb.mem_wr    : ma.mem_wr;
  wire [3:0]   w_obs_wstrb = r_sel ? mb.mem_wstrb : ma.mem_wstrb;
  wire [31:0]  w_obs_addr  = r_sel ? mb.mem_addr  : ma.mem_addr;
  wire [31:0]  w_obs_wdata = r_sel ? mb.mem_wdata : ma.mem_wdata;
  wire         w_obs_err   = r_sel ? mb.mem_err   : ma.mem_err;
  wire         w_obs_stall = r_sel ? sb.stallreq  : sa.stallreq;
  wire [31:0]  w_obs_rdata = r_sel ? sb.data_sram_rdata : sa.data_sram_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Issue monitor: counts mem_req rising edges and the gap (in cycles)
  // between the previous falling edge and the latest rising edge.
  // --------------------------------------------------------------------------
  int   r_cyc      = 0;
  int   r_fall_cyc = 0;
  int   r_gap      = 0;
  int   n_issue    = 0;
  logic r_prev_req = 1'b0;

  always @(negedge clk) begin
    r_cyc      <= r_cyc + 1;
    r_prev_req <= w_obs_req;
    if (w_obs_req && !r_prev_req) begin
      n_issue <= n_issue + 1;
      r_gap   <= r_cyc - r_fall_cyc;
    end
    if (!w_obs_req && r_prev_req) begin
      r_fall_cyc <= r_cyc;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t q_txn [$];

  typedef struct {
    logic        sel;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // REQ cycle carrying the ack, 0 = never
    logic [31:0] mrdata;
    logic        spur;       // also drive a spurious ack during DONE
    logic [31:0] exp_addr;
    int          exp_stall;  // cycles with stallreq = 1
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  // One CPU access. Starts on the next clock, memory acks on REQ cycle
  // v.ack_at, returns after the DONE cycle has been sampled (en still high).
  task automatic access(input int idx, input vec_t v);
    int   stall_n;
    int   req_n;
    bit   seen_req;
    bit   done;
    txn_t t;
    @(posedge clk); #1;
    r_sel   = v.sel;
    r_en    = 1'b1;
    r_wen   = v.wen;
    r_addr  = v.addr;
    r_wdata = v.wdata;
    r_ack   = 1'b0;
    q_txn.push_back('{wr: (v.wen != 4'b0000), strb: v.wen, addr: v.exp_addr, wdata: v.wdata});
    stall_n  = 0;
    req_n    = 0;
    seen_req = 1'b0;
    done     = 1'b0;
    t        = '0;
    for (int c = 0; c < c_budget && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (w_obs_req) begin
        req_n++;
        if (!seen_req) begin
          seen_req = 1'b1;
          if (q_txn.size() == 0) begin
            chk($sformatf("v%0d unexpected issue", idx), 32'd1, 32'd0);
          end else begin
            t = q_txn.pop_front();
          end
        end
        r_ack    = (req_n == v.ack_at);
        r_mrdata = r_ack ? v.mrdata : 32'h0BAD_0BAD;
      end else begin
        r_ack    = seen_req & v.spur;
        r_mrdata = 32'hFFFF_0000;
      end
      @(negedge clk);
      if (w_obs_req) begin
        chk($sformatf("v%0d mem_addr", idx),  w_obs_addr,         t.addr);
        chk($sformatf("v%0d mem_wr", idx),    32'(w_obs_wr),      32'(t.wr));
        chk($sformatf("v%0d mem_wstrb", idx), 32'(w_obs_wstrb),   32'(t.strb));
        chk($sformatf("v%0d mem_wdata", idx), w_obs_wdata,        t.wdata);
      end
      if (w_obs_stall) stall_n++;
      else             done = 1'b1;
    end
    chk($sformatf("v%0d issued", idx),        32'(seen_req),  32'd1);
    chk($sformatf("v%0d released", idx),      32'(done),      32'd1);
    chk($sformatf("v%0d stall cycles", idx),  32'(stall_n),   32'(v.exp_stall));
    chk($sformatf("v%0d rdata", idx),         w_obs_rdata,    v.exp_rdata);
    chk($sformatf("v%0d mem_err", idx),       32'(w_obs_err), 32'(v.exp_err));
    chk($sformatf("v%0d req in DONE", idx),   32'(w_obs_req), 32'd0);
  endtask

  // Idle cycle with a spurious ack and garbage read data on the memory port.
  task automatic idle_gap(input int idx, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    r_en     = 1'b0;
    r_ack    = 1'b1;
    r_mrdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk($sformatf("gap%0d mem_req", idx),  32'(w_obs_req),   32'd0);
    chk($sformatf("gap%0d stallreq", idx), 32'(w_obs_stall), 32'd0);
    chk($sformatf("gap%0d rdata", idx),    w_obs_rdata,      exp_rdata);
    @(posedge clk); #1;
    r_ack = 1'b0;
  endtask

  initial begin
    int n0;
    //            sel  wen      addr          wdata         ack mrdata        spur  exp_addr      stall exp_rdata     err
    vecs[0] = '{1'b0, 4'b0000, 32'h1000_0006, 32'h0000_0000, 1, 32'h8899_AABB, 1'b1, 32'h1000_0004, 2, 32'h8899_AABB, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 32'h2000_0013, 32'h00CC_0000, 5, 32'h7777_7777, 1'b1, 32'h2000_0010, 6, 32'h8899_AABB, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 32'h0000_0100, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 32'h0000_0100, 4, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 4'b0000, 32'h3000_0008, 32'h0000_0000, 4, 32'hCAFE_F00D, 1'b0, 32'h3000_0008, 5, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 4'b0000, 32'h3000_000D, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 32'h3000_000C, 5, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b1, 4'b1111, 32'h3000_0010, 32'h5555_AAAA, 0, 32'h0000_0000, 1'b0, 32'h3000_0010, 5, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{1'b1, 4'b0000, 32'h3000_0020, 32'h0000_0000, 2, 32'h0A0B_0C0D, 1'b0, 32'h3000_0020, 3, 32'h0A0B_0C0D, 1'b0};
    vecs[7] = '{1'b0, 4'b0000, 32'h4000_0001, 32'h0000_0000, 1, 32'h1111_2222, 1'b0, 32'h4000_0000, 2, 32'h1111_2222, 1'b0};
    vecs[8] = '{1'b0, 4'b0011, 32'h4000_0006, 32'h0000_BEEF, 2, 32'h9999_9999, 1'b0, 32'h4000_0004, 3, 32'h1111_2222, 1'b0};

    resetn   = 1'b0;
    r_sel    = 1'b0;
    r_en     = 1'b0;
    r_wen    = 4'b0000;
    r_addr   = 32'h0;
    r_wdata  = 32'h0;
    r_ack    = 1'b0;
    r_mrdata = 32'h0;

    // Reset state.
    #2;
    chk("reset mem_req",   32'(w_obs_req),   32'd0);
    chk("reset mem_wr",    32'(w_obs_wr),    32'd0);
    chk("reset mem_wstrb", 32'(w_obs_wstrb), 32'd0);
    chk("reset mem_addr",  w_obs_addr,       32'd0);
    chk("reset mem_wdata", w_obs_wdata,      32'd0);
    chk("reset rdata",     w_obs_rdata,      32'd0);
    chk("reset mem_err",   32'(w_obs_err),   32'd0);
    #10;
    resetn = 1'b1;
    @(negedge clk);
    chk("idle stallreq", 32'(w_obs_stall), 32'd0);
    chk("idle mem_req",  32'(w_obs_req),   32'd0);

    // Table of isolated accesses, each followed by a spurious-ack idle cycle.
    for (int i = 0; i < 6; i++) begin
      access(i, vecs[i]);
      idle_gap(i, vecs[i].exp_rdata);
    end

    // Reset asserted on the 2nd REQ cycle of a read on B (err=1, rdata!=0).
    @(posedge clk); #1;
    r_sel  = 1'b1;
    r_en   = 1'b1;
    r_wen  = 4'b0000;
    r_addr = 32'h3000_0040;
    r_ack  = 1'b0;
    @(posedge clk); #1;
    chk("rst REQ1 mem_req", 32'(w_obs_req), 32'd1);
    @(posedge clk); #1;
    chk("rst REQ2 mem_req", 32'(w_obs_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst async mem_req",  32'(w_obs_req),   32'd0);
    chk("rst async stallreq", 32'(w_obs_stall), 32'd0);
    chk("rst async rdata",    w_obs_rdata,      32'd0);
    chk("rst async mem_err",  32'(w_obs_err),   32'd0);
    chk("rst async mem_addr", w_obs_addr,       32'd0);
    r_en = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst release mem_req",  32'(w_obs_req),   32'd0);
    chk("rst release stallreq", 32'(w_obs_stall), 32'd0);

    access(6, vecs[6]);
    idle_gap(6, vecs[6].exp_rdata);

    // Back-to-back load then store on A with en held high across DONE.
    #1;
    n0 = n_issue;
    access(7, vecs[7]);
    access(8, vecs[8]);
    idle_gap(8, vecs[8].exp_rdata);
    #1;
    chk("b2b issue count", 32'(n_issue - n0), 32'd2);
    chk("b2b reissue gap", 32'(r_gap),        32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule : tb_data_sram_bridge

`default_nettype wire
